// File: rtl/ram_bank_param.sv
// ram_bank_param: parametrised single-port synchronous RAM bank.
// Byte-lane writes, req/ready handshake, pipelined reads with a read-valid
// strobe, out-of-range error strobe and a hardware init/clear sequencer that
// fills every location with INIT_VAL after reset or a soft clear.

module ram_bank_param #(
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 8192,
    parameter int                BYTE_W   = 8,
    parameter int                RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    localparam int               NB       = DATA_W / BYTE_W,
    localparam int               ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] datain,
    input  logic [NB-1:0]     be,
    input  logic              clr,
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] dataout,
    output logic              rvalid,
    output logic              err
);

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                in_range;
    logic                accept;
    logic                wr_go;
    logic                wr_oor;
    logic                rd_go;
    logic [DATA_W-1:0]   rd_word;
    logic                wr_err_q;

    // Read pipeline: stage 0 is loaded at the accept edge, the last stage drives the outputs.
    logic                vld_q [RD_LAT];
    logic                oor_q [RD_LAT];
    logic [DATA_W-1:0]   dat_q [RD_LAT];

    assign in_range = ({1'b0, addr} < DEPTH_V);
    // clr wins over req in the same IDLE cycle, so the request is simply not taken.
    assign accept   = (state == ST_IDLE) && req && !clr;
    assign wr_go    = accept && wr && in_range;
    assign wr_oor   = accept && wr && !in_range;
    assign rd_go    = accept && !wr;
    assign rd_word  = in_range ? mem[addr] : '0;

    // State register.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together from pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic: INIT runs exactly DEPTH cycles, clr in IDLE restarts it.
    // NOTE: the default assignment up front keeps this combinational block from
    // inferring a latch on paths that do not change state.
    always_comb begin
        state_d = state;
        case (state)
            ST_INIT: if (cnt == LAST_CNT) state_d = ST_IDLE;
            ST_IDLE: if (clr)             state_d = ST_INIT;
            default:                      state_d = ST_INIT;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b1;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
            default: begin
                ready = 1'b0;
                busy  = 1'b1;
            end
        endcase
    end

    // Init counter: walks 0..DEPTH-1 during INIT, parked at 0 otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (state == ST_INIT) begin
            cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // Storage array: init fill or byte-lane merge of an accepted in-range write.
    // NOTE: the array has no reset; its contents are defined by the init sequencer,
    // which keeps it mappable onto plain RAM macros.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[cnt] <= INIT_VAL;
        end else if (wr_go) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[addr][i*BYTE_W +: BYTE_W] <= datain[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Read pipeline: each stage's data only moves with a valid, so the last
    // stage holds the most recent read result between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < RD_LAT; k++) begin
                vld_q[k] <= 1'b0;
                oor_q[k] <= 1'b0;
                dat_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= rd_go;
            oor_q[0] <= rd_go && !in_range;
            if (rd_go) dat_q[0] <= rd_word;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                oor_q[k] <= oor_q[k-1];
                if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
            end
        end
    end

    // Out-of-range write error strobe, one cycle after the accept edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_oor;
        end
    end

    assign rvalid  = vld_q[RD_LAT-1];
    assign dataout = dat_q[RD_LAT-1];
    assign err     = wr_err_q | (vld_q[RD_LAT-1] & oor_q[RD_LAT-1]);

endmodule

// File: doc/ram_bank_param.md
Name: ram_bank_param

Overview:
- Parametrised single-port synchronous RAM; successor to the fixed 8k x 16 RAM used in the RAM bench.
- Generalised in data width, depth (any depth, not only powers of two) and read latency.
- Adds byte-lane write enables, a request/ready handshake, a read-valid strobe, an out-of-range error flag and a hardware init/clear sequencer.
- Sits behind the bench interface as the DUT; also used as a generic storage bank in the FIFO/AXI/APB work.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of BYTE_W.
- DEPTH, 8192, number of words; any value >= 2.
- BYTE_W, 8, bits per write-enable lane; NB = DATA_W/BYTE_W lanes.
- RD_LAT, 1, read latency in cycles; legal values are 1 or 2.
- INIT_VAL, 0, DATA_W-bit word written to every location during init.
- ADDR_W (derived), $clog2(DEPTH), address width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access request; accepted when req && ready.
- wr  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  word address.
- datain  in  DATA_W  write data.
- be  in  NB  byte-lane enables for writes; ignored on reads.
- clr  in  1  soft clear request; acted on only in IDLE.
- ready  out  1  block accepts requests.
- busy  out  1  init/clear sequence in progress.
- dataout  out  DATA_W  read data; holds its value until the next read completes.
- rvalid  out  1  one-cycle strobe marking dataout as new.
- err  out  1  out-of-range flag; one-cycle strobe.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: ready=0, busy=1, rvalid=0, err=0, dataout=0.
  - Read pipeline flushed; FSM forced to INIT; init counter cleared to 0.
  - The memory array itself is not reset.
- FSM states: INIT, IDLE.
- INIT:
  - Each cycle writes INIT_VAL to mem[cnt], then cnt++.
  - The cycle that writes cnt == DEPTH-1 transitions to IDLE.
  - Takes exactly DEPTH cycles.
  - In INIT: ready=0, busy=1; req and clr are ignored.
- IDLE:
  - ready=1, busy=0.
  - clr=1 -> INIT with cnt=0 on the next edge. clr has priority over req in the same cycle; that req is not accepted.
- Reset asserted during INIT, or with reads in flight: init restarts from 0 after release; pending rvalid and err strobes are dropped.
- Write (req && ready && wr, addr < DEPTH):
  - For each lane i with be[i]=1, mem[addr][i*BYTE_W +: BYTE_W] = datain lane i; other lanes are unchanged.
  - be=0 is a legal no-op.
  - Writes never assert rvalid.
- Read (req && ready && !wr, addr < DEPTH):
  - Data is sampled from the array at the accept edge.
  - rvalid=1 and dataout=mem[addr] appear RD_LAT cycles after the accept edge.
  - Back-to-back reads are allowed every cycle, giving a fully pipelined stream of one rvalid per accepted read, in order.
- A read accepted the cycle after a write to the same address returns the newly written data.
- Out of range (addr >= DEPTH; possible only when DEPTH is not a power of two):
  - Write: dropped; err pulses 1 cycle after the accept edge.
  - Read: returns dataout=0 with rvalid; err pulses in the same cycle as that rvalid.
- rvalid and err are low in every cycle not listed above.

Test Plan:
- Reset/init: DEPTH=12, INIT_VAL=16'hA5A5; hold reset=0 20ns, then release -> busy=1 and ready=0 for exactly 12 cycles, then ready=1; reads of addr 0..11 all return 16'hA5A5.
- Byte enables: write 16'h1234 be=2'b11 to addr 3, then 16'hFF00 be=2'b10 -> read addr 3 returns 16'hFF34; a write with be=2'b00 leaves it at 16'hFF34.
- Latency/pipelining: RD_LAT=2; issue 4 consecutive reads of addr 0..3 holding 16'h0000, 16'h1111, 16'h2222, 16'h3333 -> rvalid high on cycles N+2..N+5 with those values in order; dataout holds 16'h3333 afterwards.
- Write-then-read: write 16'hBEEF to addr 5, then read addr 5 on the next cycle -> 16'hBEEF.
- Out of range: DEPTH=12; write to addr 13 -> err pulse and no array change; read addr 13 -> dataout=0, rvalid=1 and err=1 in the same cycle.
- clr/reset collision: assert clr and req (read addr 2) in the same IDLE cycle -> read not accepted, no rvalid, busy for DEPTH cycles. Assert reset at init cycle 5 -> after release, init restarts and takes the full DEPTH cycles.
